// File: rtl/add_sub_arbiter.sv
// Shared 32-bit add/sub unit: bs = sub ? -b : b, 33-bit sum, magnitude result.
// Latency: purely combinational, no state.
// Backpressure: none; the caller registers inputs and outputs.
module add_sub_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] result,
  output logic        c,
  output logic        overflow,
  output logic        zero
);

  logic [31:0] bs;
  logic [32:0] sum;

  // Two's-complement negate b for subtraction, add, then fold to magnitude.
  always_comb begin
    bs       = sub ? (~b + 32'd1) : b;
    sum      = {1'b0, a} + {1'b0, bs};
    c        = sum[32];
    overflow = (a[31] == bs[31]) && (sum[31] != a[31]);
    result   = sum[31] ? (~sum[31:0] + 32'd1) : sum[31:0];
    zero     = (result == 32'd0);
  end

endmodule

// Round-robin arbiter/sequencer sharing one add_sub_32 between two requesters.
// Latency: accept at edge k, rsp_* registered at edge k+1; one op per 3 cycles.
// Backpressure: response held while rsp_ready is low; no request accepted until consumed.
module add_sub_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_c,
  output logic        rsp_overflow,
  output logic        rsp_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Arbitration and operand registers
  logic        last_q;
  logic        grant_vld;
  logic        grant_id;
  logic        accept;
  logic [31:0] op_a_q, op_b_q;
  logic        op_sub_q;
  logic        op_id_q;

  // Shared unit outputs
  logic [31:0] alu_result;
  logic        alu_c, alu_overflow, alu_zero;

  // Grant: a lone valid wins; on contention the requester that did not win last time wins.
  always_comb begin
    grant_vld = req0_valid || req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, readies and busy. Readies are gated by rst_n so nothing is accepted during reset.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = rst_n && grant_vld && !grant_id;
        req1_ready = rst_n && grant_vld && grant_id;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        busy    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        busy = 1'b1;
        if (rsp_valid && rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the winner's operation and remember who won for the next contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      op_sub_q <= 1'b0;
      op_id_q  <= 1'b0;
    end else if (accept) begin
      last_q   <= grant_id;
      op_id_q  <= grant_id;
      op_a_q   <= grant_id ? req1_a   : req0_a;
      op_b_q   <= grant_id ? req1_b   : req0_b;
      op_sub_q <= grant_id ? req1_sub : req0_sub;
    end
  end

  // The single shared arithmetic unit, fed only from the operand registers.
  add_sub_32 u_add_sub (
    .a        (op_a_q),
    .b        (op_b_q),
    .sub      (op_sub_q),
    .result   (alu_result),
    .c        (alu_c),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  // Response register: loaded at the end of EXEC, held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 32'd0;
      rsp_c        <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= op_id_q;
      rsp_result   <= alu_result;
      rsp_c        <= alu_c;
      rsp_overflow <= alu_overflow;
      rsp_zero     <= alu_zero;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Bench for add_sub_arbiter: directed cases plus random traffic against a behavioural model.
// Latency: checks outputs every cycle at the falling edge.
// Backpressure: randomises rsp_ready and holds it low in a dedicated phase.
module tb_add_sub_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_c, rsp_overflow, rsp_zero, busy;

  add_sub_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_c(rsp_c), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  // Reference arithmetic from plain integer maths on 64-bit values.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 output logic [31:0] res, output logic c, output logic ov, output logic z);
    longint sa, sb, ua, ub, t, sl, mag;
    logic [31:0] low;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (sub) begin
      // Negating zero wraps to zero in 32 bits, so subtracting 0 produces no carry.
      c = (b != 32'd0) && (ua >= ub);
      // Negating the most negative value wraps to itself, so the unit ends up adding it.
      t = (b == 32'h8000_0000) ? sa + sb : sa - sb;
    end else begin
      c = (ua + ub) > 64'sd4294967295;
      t = sa + sb;
    end
    ov  = (t > SMAX) || (t < SMIN);
    low = t[31:0];
    sl  = longint'($signed(low));
    mag = (sl < 0) ? -sl : sl;
    res = mag[31:0];
    z   = (res == 32'd0);
  endfunction

  // Model: outstanding operation with an age (-1 none, 0 executing, 1 response due).
  int          age = -1;
  logic        last_m = 1'b1;
  logic        m_id;
  logic [31:0] m_res;
  logic        m_c, m_ov, m_z;

  // Last cycle's observations and model handshake result.
  logic        obs_r0, obs_r1, obs_rv, obs_busy, obs_id, obs_c, obs_ov, obs_z;
  logic [31:0] obs_res;
  logic        last_hs, last_hid;

  task automatic do_cycle(input logic iv0, input logic [31:0] ia0, input logic [31:0] ib0, input logic is0,
                          input logic iv1, input logic [31:0] ia1, input logic [31:0] ib1, input logic is1,
                          input logic irr);
    logic er0, er1;
    req0_valid = iv0; req0_a = ia0; req0_b = ib0; req0_sub = is0;
    req1_valid = iv1; req1_a = ia1; req1_b = ib1; req1_sub = is1;
    rsp_ready  = irr;
    @(negedge clk);
    obs_r0 = req0_ready; obs_r1 = req1_ready; obs_rv = rsp_valid; obs_busy = busy;
    obs_id = rsp_id; obs_res = rsp_result; obs_c = rsp_c; obs_ov = rsp_overflow; obs_z = rsp_zero;
    er0 = 1'b0;
    er1 = 1'b0;
    if (age < 0) begin
      if (iv0 && iv1) begin
        er0 = last_m;
        er1 = !last_m;
      end else begin
        er0 = iv0;
        er1 = iv1;
      end
    end
    check_val("ready0", 32'(obs_r0), 32'(er0));
    check_val("ready1", 32'(obs_r1), 32'(er1));
    check_val("busy", 32'(obs_busy), 32'(age >= 0));
    check_val("rsp_valid", 32'(obs_rv), 32'(age == 1));
    if (age == 1) begin
      check_val("rsp_id", 32'(obs_id), 32'(m_id));
      check_val("rsp_result", obs_res, m_res);
      check_val("rsp_c", 32'(obs_c), 32'(m_c));
      check_val("rsp_overflow", 32'(obs_ov), 32'(m_ov));
      check_val("rsp_zero", 32'(obs_z), 32'(m_z));
    end
    last_hs  = er0 || er1;
    last_hid = er1;
    if (last_hs) begin
      age    = 0;
      m_id   = er1;
      last_m = er1;
      if (er1) ref_op(ia1, ib1, is1, m_res, m_c, m_ov, m_z);
      else     ref_op(ia0, ib0, is0, m_res, m_c, m_ov, m_z);
    end else if (age == 0) begin
      age = 1;
    end else if (age == 1 && irr) begin
      age = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic irr);
    do_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, irr);
  endtask

  // One requester issues a single op; check latency and the exact response fields.
  task automatic issue(input string tag, input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] eres, input logic ec, input logic eov, input logic ez);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      do_cycle(!id, a, b, sub, id, a, b, sub, 1'b1);
      got = last_hs && (last_hid == id);
    end
    check_val({tag, "_handshake"}, 32'(got), 32'd1);
    idle_cycle(1'b1);
    check_val({tag, "_exec_rv"}, 32'(obs_rv), 32'd0);
    idle_cycle(1'b1);
    check_val({tag, "_rv"}, 32'(obs_rv), 32'd1);
    check_val({tag, "_id"}, 32'(obs_id), 32'(id));
    check_val({tag, "_result"}, obs_res, eres);
    check_val({tag, "_c"}, 32'(obs_c), 32'(ec));
    check_val({tag, "_ov"}, 32'(obs_ov), 32'(eov));
    check_val({tag, "_zero"}, 32'(obs_z), 32'(ez));
    idle_cycle(1'b1);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rv"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
    check_val({tag, "_rsp"}, rsp_result, 32'd0);
    check_val({tag, "_flags"}, 32'({rsp_id, rsp_c, rsp_overflow, rsp_zero}), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic        first;
    logic        g_prev;
    int          n_grants;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_sub = 1'b0;
    rsp_ready = 1'b1;
    #3;
    check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle(1'b1);

    // Reset in the middle of EXEC drops the operation.
    do_cycle(1'b1, 32'd9, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check_val("rst_pre_hs", 32'(obs_r0), 32'd1);
    #2;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_exec");
    @(posedge clk); #1;
    check_val("rst_hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
    rst_n  = 1'b1;
    age    = -1;
    last_m = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle(1'b1);
    check_val("rst_no_rsp", 32'(obs_rv), 32'd0);
    do_cycle(1'b1, 32'd2, 32'd2, 1'b0, 1'b1, 32'd3, 32'd3, 1'b0, 1'b1);
    check_val("rst_first_grant0", 32'({obs_r0, obs_r1}), 32'b10);
    idle_cycle(1'b1); idle_cycle(1'b1); idle_cycle(1'b1);

    // Directed arithmetic cases.
    issue("sub_carry", 1'b0, 32'd5, 32'd3, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
    issue("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    issue("sub_borrow", 1'b1, 32'd3, 32'd5, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
    issue("sub_zero", 1'b1, 32'd7, 32'd7, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);

    // Round robin under continuous contention: last winner was 1, so 0,1,0,1.
    n_grants = 0;
    for (int i = 0; i < 12; i++) begin
      do_cycle(1'b1, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)),
               1'b1, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)), 1'b1);
      check_val("rr_onehot", 32'(obs_r0 && obs_r1), 32'd0);
      if (obs_r0 || obs_r1) begin
        check_val("rr_order", 32'(obs_r1), 32'(n_grants % 2));
        n_grants++;
      end
    end
    check_val("rr_count", 32'(n_grants), 32'd4);

    // Backpressure: response held for 5 cycles, then the other requester is granted.
    do_cycle(1'b1, 32'd100, 32'd58, 1'b1, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
    check_val("bp_grant0", 32'(obs_r0), 32'd1);
    idle_cycle(1'b0);
    first = 1'b1;
    held  = 32'd0;
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, 32'd5, 32'd5, 1'b0, 1'b1, 32'd6, 32'd6, 1'b0, 1'b0);
      check_val("bp_busy", 32'(obs_busy), 32'd1);
      check_val("bp_ready", 32'({obs_r0, obs_r1}), 32'd0);
      if (!first) check_val("bp_stable", obs_res, held);
      held  = obs_res;
      first = 1'b0;
    end
    check_val("bp_result", held, 32'd42);
    do_cycle(1'b1, 32'd5, 32'd5, 1'b0, 1'b1, 32'd6, 32'd6, 1'b0, 1'b1);
    check_val("bp_consume_rv", 32'(obs_rv), 32'd1);
    do_cycle(1'b1, 32'd5, 32'd5, 1'b0, 1'b1, 32'd6, 32'd6, 1'b0, 1'b1);
    check_val("bp_next_grant1", 32'({obs_r0, obs_r1}), 32'b01);
    idle_cycle(1'b1); idle_cycle(1'b1); idle_cycle(1'b1);

    // Random traffic: requesters raise and drop valid freely, consumer stalls at random.
    g_prev = last_m;
    for (int i = 0; i < 1500; i++) begin
      do_cycle(1'($urandom_range(0, 2) != 0), rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) != 0), rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0));
      check_val("rand_onehot", 32'(obs_r0 && obs_r1), 32'd0);
    end
    g_prev = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
